// File: rtl/ddr_cmd_issuer.sv
// DDR4 closed-page command issuer: one request at a time (ACT, CAS, PRE) with periodic REF
// and delay-line data-phase start pulses for the write driver and read checker.
module ddr_cmd_issuer #(
    parameter int T_RCD  = 4,
    parameter int T_RP   = 4,
    parameter int T_RAS  = 10,
    parameter int CL     = 5,
    parameter int CWL    = 4,
    parameter int T_WR   = 3,
    parameter int T_RTP  = 2,
    parameter int T_RFC  = 8,
    parameter int T_REFI = 100
) (
    input  logic        clock_t,
    input  logic        reset_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_rw,
    input  logic        req_bl8,
    input  logic [1:0]  req_bg,
    input  logic [1:0]  req_ba,
    input  logic [14:0] req_row,
    input  logic [9:0]  req_col,
    output logic        cs_n,
    output logic        act_n,
    output logic        ras_n_a16,
    output logic        cas_n_a15,
    output logic        we_n_a14,
    output logic [1:0]  bg_addr,
    output logic [1:0]  ba_addr,
    output logic        addr13,
    output logic        bc_n_a12,
    output logic        addr11,
    output logic        ap_a10,
    output logic [9:0]  addr9_0,
    output logic        wr_data_start,
    output logic        rd_data_start,
    output logic        ref_overrun
);

    localparam int WAIT_W = 10;
    localparam int REFI_W = (T_REFI > 2) ? $clog2(T_REFI) : 1;
    localparam logic [REFI_W-1:0] REFI_LAST = REFI_W'(T_REFI - 1);

    // CAS-to-PRE distance: the later of the tRAS bound and the data-path bound
    localparam int RAS_AFTER_CAS = T_RAS - T_RCD;
    localparam int WR8_RAW = CWL + 4 + T_WR;
    localparam int WR4_RAW = CWL + 2 + T_WR;
    localparam int REC_WR8 = (RAS_AFTER_CAS > WR8_RAW) ? RAS_AFTER_CAS : WR8_RAW;
    localparam int REC_WR4 = (RAS_AFTER_CAS > WR4_RAW) ? RAS_AFTER_CAS : WR4_RAW;
    localparam int REC_RD  = (RAS_AFTER_CAS > T_RTP) ? RAS_AFTER_CAS : T_RTP;

    // Pin word: {cs,act,ras,cas,we, bg[1:0], ba[1:0], a13, a12, a11, a10, a9_0}
    localparam logic [22:0] PINS_DES = {5'b11111, 18'd0};

    typedef enum logic [3:0] {
        S_IDLE       = 4'd0,
        S_ACT        = 4'd1,
        S_RCD_WAIT   = 4'd2,
        S_CAS        = 4'd3,
        S_RECOV_WAIT = 4'd4,
        S_PRE        = 4'd5,
        S_RP_WAIT    = 4'd6,
        S_REF        = 4'd7,
        S_RFC_WAIT   = 4'd8
    } state_e;

    state_e              state_q, state_d;
    logic [WAIT_W-1:0]   wait_q, wait_d;
    logic [REFI_W-1:0]   ref_cnt_q, ref_cnt_d;
    logic                ref_pending_q, ref_pending_d;
    logic                ref_overrun_q, ref_overrun_d;
    logic                rw_q, rw_d;
    logic                bl8_q, bl8_d;
    logic [1:0]          bg_q, bg_d;
    logic [1:0]          ba_q, ba_d;
    logic [14:0]         row_q, row_d;
    logic [9:0]          col_q, col_d;
    logic [22:0]         pins_q, pins_d;
    logic                req_ready_q, req_ready_d;
    logic [CWL:0]        wr_pipe_q, wr_pipe_d;
    logic [CL:0]         rd_pipe_q, rd_pipe_d;

    logic                hs_s;
    logic                wrap_s;
    logic [WAIT_W-1:0]   rec_s;

    assign hs_s   = req_valid && req_ready_q;
    assign wrap_s = (ref_cnt_q == REFI_LAST);
    assign rec_s  = rw_q ? (bl8_q ? WAIT_W'(REC_WR8) : WAIT_W'(REC_WR4)) : WAIT_W'(REC_RD);

    // State, latched request, refresh bookkeeping and output registers
    always_ff @(posedge clock_t or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= S_IDLE;
            wait_q        <= {WAIT_W{1'b0}};
            ref_cnt_q     <= {REFI_W{1'b0}};
            ref_pending_q <= 1'b0;
            ref_overrun_q <= 1'b0;
            rw_q          <= 1'b0;
            bl8_q         <= 1'b0;
            bg_q          <= 2'd0;
            ba_q          <= 2'd0;
            row_q         <= 15'd0;
            col_q         <= 10'd0;
            pins_q        <= PINS_DES;
            req_ready_q   <= 1'b0;
            wr_pipe_q     <= {(CWL+1){1'b0}};
            rd_pipe_q     <= {(CL+1){1'b0}};
        end else begin
            state_q       <= state_d;
            wait_q        <= wait_d;
            ref_cnt_q     <= ref_cnt_d;
            ref_pending_q <= ref_pending_d;
            ref_overrun_q <= ref_overrun_d;
            rw_q          <= rw_d;
            bl8_q         <= bl8_d;
            bg_q          <= bg_d;
            ba_q          <= ba_d;
            row_q         <= row_d;
            col_q         <= col_d;
            pins_q        <= pins_d;
            req_ready_q   <= req_ready_d;
            wr_pipe_q     <= wr_pipe_d;
            rd_pipe_q     <= rd_pipe_d;
        end
    end

    // Next-state, wait counter, request latch and refresh interval tracking
    always_comb begin
        state_d       = state_q;
        wait_d        = wait_q;
        rw_d          = rw_q;
        bl8_d         = bl8_q;
        bg_d          = bg_q;
        ba_d          = ba_q;
        row_d         = row_q;
        col_d         = col_q;
        ref_cnt_d     = wrap_s ? {REFI_W{1'b0}} : ref_cnt_q + {{(REFI_W-1){1'b0}}, 1'b1};
        ref_overrun_d = ref_overrun_q | (wrap_s & ref_pending_q);
        // A fresh expiry wins over the clear from a REF issued in the same cycle
        if (wrap_s) begin
            ref_pending_d = 1'b1;
        end else if (state_q == S_REF) begin
            ref_pending_d = 1'b0;
        end else begin
            ref_pending_d = ref_pending_q;
        end

        case (state_q)
            S_IDLE: begin
                if (hs_s) begin
                    state_d = S_ACT;
                    rw_d    = req_rw;
                    bl8_d   = req_bl8;
                    bg_d    = req_bg;
                    ba_d    = req_ba;
                    row_d   = req_row;
                    col_d   = req_col;
                end else if (ref_pending_q || wrap_s) begin
                    state_d = S_REF;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_ACT: begin
                if (T_RCD > 1) begin
                    state_d = S_RCD_WAIT;
                    wait_d  = WAIT_W'(T_RCD - 1);
                end else begin
                    state_d = S_CAS;
                end
            end
            S_RCD_WAIT: begin
                if (wait_q <= 10'd1) begin
                    state_d = S_CAS;
                end else begin
                    wait_d = wait_q - 10'd1;
                end
            end
            S_CAS: begin
                if (rec_s > 10'd1) begin
                    state_d = S_RECOV_WAIT;
                    wait_d  = rec_s - 10'd1;
                end else begin
                    state_d = S_PRE;
                end
            end
            S_RECOV_WAIT: begin
                if (wait_q <= 10'd1) begin
                    state_d = S_PRE;
                end else begin
                    wait_d = wait_q - 10'd1;
                end
            end
            S_PRE: begin
                if (T_RP > 1) begin
                    state_d = S_RP_WAIT;
                    wait_d  = WAIT_W'(T_RP - 1);
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RP_WAIT: begin
                if (wait_q <= 10'd1) begin
                    state_d = S_IDLE;
                end else begin
                    wait_d = wait_q - 10'd1;
                end
            end
            S_REF: begin
                if (T_RFC > 1) begin
                    state_d = S_RFC_WAIT;
                    wait_d  = WAIT_W'(T_RFC - 1);
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RFC_WAIT: begin
                if (wait_q <= 10'd1) begin
                    state_d = S_IDLE;
                end else begin
                    wait_d = wait_q - 10'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Registered pin/ready/pulse values are decoded from the state being entered
    always_comb begin
        pins_d      = PINS_DES;
        req_ready_d = (state_d == S_IDLE) && !ref_pending_d;
        wr_pipe_d   = {wr_pipe_q[CWL-1:0], (state_d == S_CAS) && rw_d};
        rd_pipe_d   = {rd_pipe_q[CL-1:0], (state_d == S_CAS) && !rw_d};
        case (state_d)
            S_ACT:   pins_d = {4'b0000, row_d[14], bg_d, ba_d, row_d[13:0]};
            S_CAS:   pins_d = {(rw_d ? 5'b01100 : 5'b01101), bg_d, ba_d,
                               1'b0, bl8_d, 1'b0, 1'b0, col_d};
            S_PRE:   pins_d = {5'b01010, bg_d, ba_d, 4'b0000, 10'd0};
            S_REF:   pins_d = {5'b01001, 18'd0};
            default: pins_d = PINS_DES;
        endcase
    end

    assign req_ready     = req_ready_q;
    assign cs_n          = pins_q[22];
    assign act_n         = pins_q[21];
    assign ras_n_a16     = pins_q[20];
    assign cas_n_a15     = pins_q[19];
    assign we_n_a14      = pins_q[18];
    assign bg_addr       = pins_q[17:16];
    assign ba_addr       = pins_q[15:14];
    assign addr13        = pins_q[13];
    assign bc_n_a12      = pins_q[12];
    assign addr11        = pins_q[11];
    assign ap_a10        = pins_q[10];
    assign addr9_0       = pins_q[9:0];
    assign wr_data_start = wr_pipe_q[CWL];
    assign rd_data_start = rd_pipe_q[CL];
    assign ref_overrun   = ref_overrun_q;

endmodule

// File: tb/tb_ddr_cmd_issuer.sv
// Bench for ddr_cmd_issuer: directed vector table and corner sequences, plus random requests
// checked every cycle against an arithmetic schedule model of the command timeline.
module tb_ddr_cmd_issuer;

    localparam int T_RCD = 4, T_RP = 4, T_RAS = 10, CL = 5, CWL = 4;
    localparam int T_WR = 3, T_RTP = 2, T_RFC = 8, T_REFI = 100;
    localparam logic [22:0] DES_W = {5'b11111, 18'd0};
    localparam logic [22:0] REF_W = {5'b01001, 18'd0};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n, ov_rst_n;
    logic req_valid, req_rw, req_bl8;
    logic [1:0] req_bg, req_ba;
    logic [14:0] req_row;
    logic [9:0] req_col;
    logic req_ready, cs_n, act_n, ras_n_a16, cas_n_a15, we_n_a14;
    logic [1:0] bg_addr, ba_addr;
    logic addr13, bc_n_a12, addr11, ap_a10;
    logic [9:0] addr9_0;
    logic wr_data_start, rd_data_start, ref_overrun;

    logic ov_ready, ov_cs, ov_act, ov_ras, ov_cas, ov_we;
    logic [1:0] ov_bg, ov_ba;
    logic ov_a13, ov_a12, ov_a11, ov_a10;
    logic [9:0] ov_a9_0;
    logic ov_wr, ov_rd, ov_overrun;

    ddr_cmd_issuer #(.T_RCD(T_RCD), .T_RP(T_RP), .T_RAS(T_RAS), .CL(CL), .CWL(CWL),
                     .T_WR(T_WR), .T_RTP(T_RTP), .T_RFC(T_RFC), .T_REFI(T_REFI)) dut (
        .clock_t(clk), .reset_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_rw(req_rw), .req_bl8(req_bl8), .req_bg(req_bg), .req_ba(req_ba),
        .req_row(req_row), .req_col(req_col), .cs_n(cs_n), .act_n(act_n),
        .ras_n_a16(ras_n_a16), .cas_n_a15(cas_n_a15), .we_n_a14(we_n_a14),
        .bg_addr(bg_addr), .ba_addr(ba_addr), .addr13(addr13), .bc_n_a12(bc_n_a12),
        .addr11(addr11), .ap_a10(ap_a10), .addr9_0(addr9_0),
        .wr_data_start(wr_data_start), .rd_data_start(rd_data_start), .ref_overrun(ref_overrun));

    // Short refresh interval so that expiries overlap the refresh recovery window
    ddr_cmd_issuer #(.T_REFI(3)) dut_ov (
        .clock_t(clk), .reset_n(ov_rst_n), .req_valid(1'b0), .req_ready(ov_ready),
        .req_rw(1'b0), .req_bl8(1'b0), .req_bg(2'd0), .req_ba(2'd0),
        .req_row(15'd0), .req_col(10'd0), .cs_n(ov_cs), .act_n(ov_act),
        .ras_n_a16(ov_ras), .cas_n_a15(ov_cas), .we_n_a14(ov_we),
        .bg_addr(ov_bg), .ba_addr(ov_ba), .addr13(ov_a13), .bc_n_a12(ov_a12),
        .addr11(ov_a11), .ap_a10(ov_a10), .addr9_0(ov_a9_0),
        .wr_data_start(ov_wr), .rd_data_start(ov_rd), .ref_overrun(ov_overrun));

    logic [22:0] dut_pins, ov_pins;
    assign dut_pins = {cs_n, act_n, ras_n_a16, cas_n_a15, we_n_a14, bg_addr, ba_addr,
                       addr13, bc_n_a12, addr11, ap_a10, addr9_0};
    assign ov_pins  = {ov_cs, ov_act, ov_ras, ov_cas, ov_we, ov_bg, ov_ba,
                       ov_a13, ov_a12, ov_a11, ov_a10, ov_a9_0};

    int n_pass = 0, n_checks = 0;
    int cyc = 0;
    bit ov_en = 1'b0;

    int m_idle_at;
    bit m_pend, m_ovr, m_ref_prev, m_ready_prev, m_hs;
    logic [22:0] m_pins [int];
    bit m_wr [int];
    bit m_rd [int];

    function automatic logic [22:0] act_w(input logic [1:0] bg, input logic [1:0] ba,
                                          input logic [14:0] row);
        return {4'b0000, row[14], bg, ba, row[13:0]};
    endfunction

    function automatic logic [22:0] cas_w(input logic rw, input logic bl8, input logic [1:0] bg,
                                          input logic [1:0] ba, input logic [9:0] col);
        return {(rw ? 5'b01100 : 5'b01101), bg, ba, 1'b0, bl8, 1'b0, 1'b0, col};
    endfunction

    function automatic logic [22:0] pre_w(input logic [1:0] bg, input logic [1:0] ba);
        return {5'b01010, bg, ba, 4'b0000, 10'd0};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
    endtask

    task automatic timeout_fail(input string name);
        n_checks++;
        $display("FAIL timeout_%s @cyc %0d: got no event expected event", name, cyc);
    endtask

    task automatic model_reset();
        m_pins.delete(); m_wr.delete(); m_rd.delete();
        m_idle_at = 0; m_pend = 1'b0; m_ovr = 1'b0;
        m_ref_prev = 1'b0; m_ready_prev = 1'b0; m_hs = 1'b0; cyc = 0;
    endtask

    // Reference: schedule each accepted request's command timeline by plain arithmetic
    task automatic model_step(input bit v, input bit rw, input bit bl8, input logic [1:0] bg,
                              input logic [1:0] ba, input logic [14:0] row, input logic [9:0] col);
        int c, cas_c, p;
        bit wrap, pend_now, ref_now, in_idle_prev, exp_ready;
        logic [22:0] exp_pins;
        c = cyc;
        wrap = (c % T_REFI) == 0;
        in_idle_prev = (c - 1) >= m_idle_at;
        m_hs = v && m_ready_prev;
        pend_now = wrap ? 1'b1 : (m_ref_prev ? 1'b0 : m_pend);
        if (wrap && m_pend) m_ovr = 1'b1;
        ref_now = 1'b0;
        if (m_hs) begin
            cas_c = c + T_RCD;
            if (rw) p = cas_c + CWL + (bl8 ? 4 : 2) + T_WR;
            else    p = cas_c + T_RTP;
            if (c + T_RAS > p) p = c + T_RAS;
            m_pins[c] = act_w(bg, ba, row);
            m_pins[cas_c] = cas_w(rw, bl8, bg, ba, col);
            m_pins[p] = pre_w(bg, ba);
            if (rw) m_wr[cas_c + CWL] = 1'b1;
            else    m_rd[cas_c + CL] = 1'b1;
            m_idle_at = p + T_RP;
        end else if (in_idle_prev && (m_pend || wrap)) begin
            ref_now = 1'b1;
            m_pins[c] = REF_W;
            m_idle_at = c + T_RFC;
        end
        m_pend = pend_now;
        m_ref_prev = ref_now;
        exp_ready = (c >= m_idle_at) && !m_pend;
        m_ready_prev = exp_ready;
        exp_pins = m_pins.exists(c) ? m_pins[c] : DES_W;
        check("pins", {9'd0, dut_pins}, {9'd0, exp_pins});
        check("req_ready", {31'd0, req_ready}, {31'd0, exp_ready});
        check("wr_data_start", {31'd0, wr_data_start}, {31'd0, m_wr.exists(c)});
        check("rd_data_start", {31'd0, rd_data_start}, {31'd0, m_rd.exists(c)});
        check("ref_overrun", {31'd0, ref_overrun}, {31'd0, m_ovr});
        if (m_pins.exists(c)) m_pins.delete(c);
        if (m_wr.exists(c)) m_wr.delete(c);
        if (m_rd.exists(c)) m_rd.delete(c);
    endtask

    task automatic tick();
        bit v, rw, bl8;
        logic [1:0] bg, ba;
        logic [14:0] row;
        logic [9:0] col;
        v = req_valid; rw = req_rw; bl8 = req_bl8; bg = req_bg; ba = req_ba;
        row = req_row; col = req_col;
        @(posedge clk);
        cyc++;
        @(negedge clk);
        model_step(v, rw, bl8, bg, ba, row, col);
        if (ov_en && cyc <= 40) begin
            if (cyc == 3) check("ov_ref_pins", {9'd0, ov_pins}, {9'd0, REF_W});
            check("ov_overrun", {31'd0, ov_overrun}, {31'd0, (cyc >= 9)});
        end
    endtask

    task automatic set_req(input bit rw, input bit bl8, input logic [1:0] bg,
                           input logic [1:0] ba, input logic [14:0] row, input logic [9:0] col);
        req_rw = rw; req_bl8 = bl8; req_bg = bg; req_ba = ba; req_row = row; req_col = col;
        req_valid = 1'b1;
    endtask

    task automatic wait_hs(input string name);
        int k;
        k = 0;
        do begin
            tick();
            k++;
        end while (!m_hs && k < 300);
        if (!m_hs) timeout_fail(name);
    endtask

    typedef struct {
        bit rw; bit bl8; logic [1:0] bg; logic [1:0] ba; logic [14:0] row; logic [9:0] col;
        int cas_off; int pulse_off; int pre_off; int rdy_off;
    } vec_t;

    initial begin
        vec_t tbl [4];
        int h, cas_o, pulse_o, pre_o, rdy_o, ref_o, act_o;
        logic [22:0] cas_pins;

        tbl[0] = '{1'b1, 1'b1, 2'd1, 2'd2, 15'h1234, 10'h0A8, 4, 8, 15, 19};
        tbl[1] = '{1'b0, 1'b0, 2'd0, 2'd3, 15'h4321, 10'h3FF, 4, 9, 10, 14};
        tbl[2] = '{1'b1, 1'b0, 2'd3, 2'd0, 15'h0001, 10'h000, 4, 8, 13, 17};
        tbl[3] = '{1'b0, 1'b1, 2'd2, 2'd1, 15'h5A5A, 10'h155, 4, 9, 10, 14};

        rst_n = 1'b0; ov_rst_n = 1'b0;
        req_valid = 1'b0; req_rw = 1'b0; req_bl8 = 1'b0; req_bg = 2'd0; req_ba = 2'd0;
        req_row = 15'd0; req_col = 10'd0;
        model_reset();
        repeat (3) @(negedge clk);
        check("rst_pins", {9'd0, dut_pins}, {9'd0, DES_W});
        check("rst_ready", {31'd0, req_ready}, 32'd0);
        check("rst_pulses", {30'd0, wr_data_start, rd_data_start}, 32'd0);
        check("rst_overrun", {31'd0, ref_overrun}, 32'd0);
        rst_n = 1'b1; ov_rst_n = 1'b1; ov_en = 1'b1;

        // Idle from reset: ready at cycle 1, REF at 100, ready back at 108
        repeat (110) begin
            tick();
            if (cyc == 1)   check("idle_ready_c1", {31'd0, req_ready}, 32'd1);
            if (cyc == 100) check("idle_ref_c100", {9'd0, dut_pins}, {9'd0, REF_W});
            if (cyc == 107) check("idle_ready_c107", {31'd0, req_ready}, 32'd0);
            if (cyc == 108) check("idle_ready_c108", {31'd0, req_ready}, 32'd1);
        end
        ov_en = 1'b0;

        for (int i = 0; i < 4; i++) begin
            set_req(tbl[i].rw, tbl[i].bl8, tbl[i].bg, tbl[i].ba, tbl[i].row, tbl[i].col);
            wait_hs("tbl_hs");
            h = cyc;
            req_valid = 1'b0;
            check("tbl_act_pins", {9'd0, dut_pins},
                  {9'd0, act_w(tbl[i].bg, tbl[i].ba, tbl[i].row)});
            cas_o = -1; pulse_o = -1; pre_o = -1; rdy_o = -1; cas_pins = DES_W;
            for (int k = 1; k <= 30; k++) begin
                tick();
                if (cas_o < 0 && (dut_pins[22:18] == 5'b01100 || dut_pins[22:18] == 5'b01101)) begin
                    cas_o = cyc - h; cas_pins = dut_pins;
                end
                if (pulse_o < 0 && (wr_data_start || rd_data_start)) pulse_o = cyc - h;
                if (pre_o < 0 && dut_pins[22:18] == 5'b01010) pre_o = cyc - h;
                if (rdy_o < 0 && req_ready) rdy_o = cyc - h;
            end
            check("tbl_cas_pins", {9'd0, cas_pins},
                  {9'd0, cas_w(tbl[i].rw, tbl[i].bl8, tbl[i].bg, tbl[i].ba, tbl[i].col)});
            check("tbl_cas_off", cas_o, tbl[i].cas_off);
            check("tbl_pulse_off", pulse_o, tbl[i].pulse_off);
            check("tbl_pre_off", pre_o, tbl[i].pre_off);
            check("tbl_ready_off", rdy_o, tbl[i].rdy_off);
        end

        // Refresh expiry inside a write: REF right after RP_WAIT->IDLE, next ACT T_RFC later
        for (int k = 0; k < 200 && (cyc % T_REFI) != 85; k++) tick();
        set_req(1'b1, 1'b1, 2'd1, 2'd1, 15'h0F0F, 10'h011);
        wait_hs("defer_hs");
        h = cyc;
        ref_o = -1; act_o = -1;
        for (int k = 1; k <= 60; k++) begin
            tick();
            if (ref_o < 0 && dut_pins == REF_W) ref_o = cyc - h;
            if (act_o < 0 && dut_pins[22:21] == 2'b00) act_o = cyc - h;
            if (m_hs) req_valid = 1'b0;
        end
        req_valid = 1'b0;
        check("defer_ref_off", ref_o, 20);
        check("defer_act_off", act_o, 29);

        // Reset during RCD_WAIT drops the request
        repeat (5) tick();
        set_req(1'b0, 1'b1, 2'd2, 2'd2, 15'h2222, 10'h022);
        wait_hs("rst_mid_hs");
        req_valid = 1'b0;
        tick();
        rst_n = 1'b0;
        #1;
        check("async_rst_pins", {9'd0, dut_pins}, {9'd0, DES_W});
        check("async_rst_ready", {31'd0, req_ready}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        set_req(1'b1, 1'b0, 2'd1, 2'd3, 15'h0ABC, 10'h033);
        act_o = -1;
        for (int k = 0; k < 30 && act_o < 0; k++) begin
            tick();
            if (m_hs) req_valid = 1'b0;
            if (dut_pins != DES_W) begin
                act_o = cyc;
                check("post_rst_first_cmd", {27'd0, dut_pins[22:18]}, 32'd0);
            end
        end
        if (act_o < 0) timeout_fail("post_rst_act");
        req_valid = 1'b0;

        // Random requests against the model
        for (int i = 0; i < 2500; i++) begin
            tick();
            if (m_hs) req_valid = 1'b0;
            if (!req_valid && $urandom_range(0, 3) == 0)
                set_req(1'($urandom), 1'($urandom), 2'($urandom), 2'($urandom),
                        15'($urandom), 10'($urandom));
        end
        req_valid = 1'b0;
        repeat (30) tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
